// File: rtl/adjust_pulser.sv
// Pushbutton front end for the mod-60 adjust path: synchronise, debounce and auto-repeat
// up/down buttons into one-cycle add/minus strobes. Define ADJUST_ACCEL_EN for faster repeats after ACCEL_AFTER pulses.
module adjust_pulser #(
  parameter int unsigned DB_CYCLES     = 500000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000,
  parameter int unsigned ACCEL_AFTER   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic btn_up,
  input  logic btn_down,
  output logic add,
  output logic minus,
  output logic busy
);

  localparam int unsigned M1   = (DB_CYCLES > REPEAT_DELAY) ? DB_CYCLES : REPEAT_DELAY;
  localparam int unsigned M2   = (M1 > REPEAT_PERIOD) ? M1 : REPEAT_PERIOD;
  localparam int unsigned MAXP = (M2 > ACCEL_AFTER) ? M2 : ACCEL_AFTER;
  localparam int unsigned CW   = $clog2(MAXP + 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, REPEAT} state_t;
  typedef enum logic [1:0] {C_NONE = 2'd0, C_UP = 2'd1, C_DN = 2'd2} code_t;

  state_t          state, state_n;
  code_t           dir, dir_n, code;
  logic [CW-1:0]   cnt, cnt_n, period_last;
  logic            up_m, up_s, dn_m, dn_s;
  logic            pulse, add_n, minus_n;

  // Two-flop synchronisers; they keep running regardless of enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_m <= 1'b0;
      up_s <= 1'b0;
      dn_m <= 1'b0;
      dn_s <= 1'b0;
    end else begin
      up_m <= btn_up;
      up_s <= up_m;
      dn_m <= btn_down;
      dn_s <= dn_m;
    end
  end

  always_comb begin
    code = C_NONE;
    if (up_s && !dn_s)      code = C_UP;
    else if (dn_s && !up_s) code = C_DN;
  end

`ifdef ADJUST_ACCEL_EN
  localparam int unsigned RW   = $clog2(ACCEL_AFTER + 1);
  localparam int unsigned FAST = (REPEAT_PERIOD / 2 < 1) ? 1 : REPEAT_PERIOD / 2;

  logic [RW-1:0] rep, rep_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rep <= '0;
    else       rep <= rep_n;
  end

  // Repeat-pulse count saturates; cleared whenever the machine is not staying in REPEAT
  always_comb begin
    rep_n = rep;
    if (state_n != REPEAT)
      rep_n = '0;
    else if (pulse && state == REPEAT && rep != RW'(ACCEL_AFTER))
      rep_n = rep + RW'(1);
  end

  assign period_last = (rep == RW'(ACCEL_AFTER)) ? CW'(FAST - 1) : CW'(REPEAT_PERIOD - 1);
`else
  assign period_last = CW'(REPEAT_PERIOD - 1);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      dir   <= C_NONE;
      add   <= 1'b0;
      minus <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dir   <= dir_n;
      add   <= add_n;
      minus <= minus_n;
      busy  <= (state_n != IDLE);
    end
  end

  // Any departure from the latched direction drops back to IDLE without a pulse
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dir_n   = dir;
    pulse   = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (code != C_NONE) begin
            dir_n   = code;
            state_n = DEBOUNCE;
            cnt_n   = '0;
          end
        end
        DEBOUNCE: begin
          if (code != dir) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (cnt == CW'(DB_CYCLES - 1)) begin
            pulse   = 1'b1;
            state_n = HOLD;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        HOLD: begin
          if (code != dir) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (cnt == CW'(REPEAT_DELAY - 1)) begin
            pulse   = 1'b1;
            state_n = REPEAT;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        REPEAT: begin
          if (code != dir) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (cnt == period_last) begin
            pulse = 1'b1;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
    add_n   = pulse && (dir == C_UP);
    minus_n = pulse && (dir == C_DN);
  end

endmodule
